// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin APB master with wait states,
// pslverr capture and ACCESS timeout abort.
module apb_req_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_W-1:0]       req_addr,
  input  logic [2*DATA_W-1:0]       req_wdata,
  input  logic [2*(DATA_W/8)-1:0]   req_strb,
  output logic [1:0]                rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [7:0]                err_cnt,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t      state;
  logic        last_grant;
  logic        owner;
  logic [15:0] wait_cnt;

  logic              winner;
  logic              grant;
  logic              timed_out;
  logic              xfer_end;
  logic              end_err;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;

  // The response cycle is kept out of the grant window so a requester never
  // sees req_ready and rsp_valid together.
  always_comb begin
    winner    = (&req_valid) ? ~last_grant : req_valid[1];
    grant     = !preset && (state == S_IDLE) && !(|rsp_valid) && (|req_valid);
    req_ready = 2'b00;
    if (grant) req_ready[winner] = 1'b1;

    sel_write = winner ? req_write[1] : req_write[0];
    sel_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    sel_strb  = winner ? req_strb[2*STRB_W-1:STRB_W] : req_strb[STRB_W-1:0];

    timed_out = (TIMEOUT != 0) && !pready && (wait_cnt == TO_LAST);
    xfer_end  = (state == S_ACCESS) && (pready || timed_out);
    end_err   = pready ? pslverr : 1'b1;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      rsp_valid  <= 2'b00;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      err_cnt    <= '0;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner      <= winner;
            last_grant <= winner;
            pwrite     <= sel_write;
            paddr      <= sel_addr;
            pstrb      <= sel_write ? sel_strb : '0;
            if (sel_write) pwdata <= sel_wdata;
            psel       <= 1'b1;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= S_ACCESS;
        end
        S_ACCESS: begin
          if (xfer_end) begin
            psel             <= 1'b0;
            penable          <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= end_err;
            rsp_rdata        <= (pready && !pwrite) ? prdata : '0;
            if (end_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            state            <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - randomized and directed bench for apb_req_arbiter
// against a transaction-level reference model.
module tb_apb_req_arbiter;

  localparam int TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_cnt;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [15:0] pwdata;
  logic [1:0]  pstrb;
  logic [15:0] prdata;
  logic        pready, pslverr;

  apb_req_arbiter #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who was granted last, erroneous-response tally, APB write-data holding register.
  int          m_last;
  int          m_errs;
  logic [15:0] m_pwdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic arm_cmd(input int i, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input logic [1:0] s);
    req_valid[i]        = 1'b1;
    req_write[i]        = w;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*16 +: 16] = d;
    req_strb[i*2 +: 2]  = s;
  endtask

  task automatic arm(input int i);
    arm_cmd(i, 1'($urandom), 8'($urandom), 16'($urandom), 2'($urandom));
  endtask

  function automatic void model_reset();
    m_last   = 1;
    m_errs   = 0;
    m_pwdata = 16'h0;
  endfunction

  // One complete transfer, starting at the negedge of the expected grant cycle
  // and ending after checking the response cycle.
  task automatic run_transfer(input int waits, input bit tmo, input bit slverr,
                              input logic [15:0] rd, input bit rearm);
    int          w, n;
    logic        wr;
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  s, exp_rdy, exp_strb;
    bit          exp_err;
    logic [15:0] exp_rd;
    @(negedge pclk); #1;
    if (req_valid == 2'b11) w = (m_last == 0) ? 1 : 0;
    else                    w = req_valid[1] ? 1 : 0;
    exp_rdy = (w == 1) ? 2'b10 : 2'b01;
    chk("grant", req_ready, exp_rdy);
    wr = req_write[w];
    a  = req_addr[w*8 +: 8];
    d  = req_wdata[w*16 +: 16];
    s  = req_strb[w*2 +: 2];
    if (wr) m_pwdata = d;
    exp_strb = wr ? s : 2'b00;
    m_last = w;

    @(negedge pclk);
    if (rearm) arm(w); else req_valid[w] = 1'b0;
    pready = 1'b0; #1;
    chk("setup_psel", psel, 1'b1);
    chk("setup_penable", penable, 1'b0);
    chk("setup_ready", req_ready, 2'b00);
    chk("setup_cmd", {pwrite, paddr, pwdata, pstrb}, {wr, a, m_pwdata, exp_strb});

    n = tmo ? TIMEOUT : waits + 1;
    for (int k = 0; k < n; k++) begin
      @(negedge pclk);
      pready  = !tmo && (k == waits);
      pslverr = pready ? slverr : 1'($urandom);
      prdata  = pready ? rd : 16'($urandom);
      #1;
      chk("access_ctl", {psel, penable, rsp_valid}, {2'b11, 2'b00});
      chk("access_cmd", {pwrite, paddr, pwdata, pstrb}, {wr, a, m_pwdata, exp_strb});
    end

    @(negedge pclk);
    pready = 1'b0; pslverr = 1'b0; #1;
    exp_err = tmo || slverr;
    exp_rd  = (tmo || wr) ? 16'h0 : rd;
    if (exp_err && m_errs < 255) m_errs++;
    chk("rsp_valid", rsp_valid, exp_rdy);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_ctl", {psel, penable}, 2'b00);
    chk("rsp_no_ready", req_ready, 2'b00);
    chk("err_cnt", err_cnt, m_errs);
  endtask

  initial begin
    preset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    model_reset();

    @(negedge pclk); #1;
    chk("rst_ctl", {psel, penable, pwrite, req_ready, rsp_valid, rsp_err}, '0);
    chk("rst_data", {paddr, pwdata, pstrb, rsp_rdata, err_cnt}, '0);
    @(posedge pclk); #1 preset = 1'b0;

    arm_cmd(0, 1'b1, 8'h00, 16'hdead, 2'b11);
    run_transfer(0, 0, 0, 16'h0, 0);

    arm(0); arm(1);
    run_transfer(0, 0, 0, 16'($urandom), 1);
    run_transfer(0, 0, 0, 16'($urandom), 1);
    run_transfer(0, 0, 0, 16'($urandom), 0);
    run_transfer(0, 0, 0, 16'($urandom), 0);

    arm_cmd(1, 1'b0, 8'h01, 16'hbeef, 2'b11);
    run_transfer(3, 0, 0, 16'h4ead, 0);

    for (int t = 0; t < 260; t++) begin
      arm_cmd(t % 2, 1'b1, 8'($urandom), 16'($urandom), 2'($urandom));
      run_transfer(0, 0, 1, 16'($urandom), 0);
    end
    chk("err_cnt_sat", err_cnt, 8'd255);

    arm_cmd(0, 1'b0, 8'h20, 16'h0, 2'b11);
    run_transfer(0, 1, 0, 16'h0, 0);

    // Reset in the middle of ACCESS.
    arm_cmd(1, 1'b1, 8'h55, 16'h1234, 2'b01);
    @(negedge pclk); #1;
    chk("rst_test_grant", req_ready, 2'b10);
    @(negedge pclk);
    req_valid[1] = 1'b0;
    @(negedge pclk);
    pready = 1'b0; #1;
    chk("rst_test_access", {psel, penable}, 2'b11);
    preset = 1'b1; #1;
    chk("rst_async_ctl", {psel, penable, rsp_valid}, 4'b0000);
    arm(0); arm(1);
    @(negedge pclk); #1;
    chk("rst_hold", {rsp_valid, req_ready}, 4'b0000);
    @(posedge pclk); #1 preset = 1'b0;
    model_reset();
    run_transfer(1, 0, 0, 16'($urandom), 1);
    run_transfer(0, 0, 0, 16'($urandom), 0);

    for (int t = 0; t < 80; t++) begin
      int i;
      if (req_valid == 2'b00 || $urandom_range(0, 2) == 0) begin
        i = $urandom_range(0, 1);
        if (!req_valid[i]) arm(i);
      end
      run_transfer($urandom_range(0, 3), $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
